// File: rtl/tick_watchdog.sv
// Tick-train watchdog: classifies each generator tick as early/good/late, reports lock, latches a sticky fault.
// Latency: all outputs registered, one cycle after the classifying edge. No backpressure; tick is a bare pulse.
// Optional TICK_WDOG_STATS_EN adds miss_total and max_interval statistics outputs.
module tick_watchdog #(
    parameter int PERIOD     = 751,
    parameter int TOL        = 2,
    parameter int CBITS      = 10,
    parameter int LOCK_CNT   = 2,
    parameter int MISS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    output logic             locked,
    output logic             early,
    output logic             late,
    output logic             fault,
    output logic [CBITS-1:0] interval
`ifdef TICK_WDOG_STATS_EN
    ,
    output logic [15:0]      miss_total,
    output logic [CBITS-1:0] max_interval
`endif
);

    generate
        if (PERIOD + TOL + 1 >= 2 ** CBITS) begin : g_cbits_too_small
            $error("tick_watchdog: CBITS too narrow for PERIOD+TOL+1");
        end
    endgenerate

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_LIMIT + 1);

    localparam logic [CBITS-1:0] EARLY_LIM = CBITS'(PERIOD - TOL);
    localparam logic [CBITS-1:0] LATE_AT   = CBITS'(PERIOD + TOL + 1);
    localparam logic [GW-1:0]    GOOD_MAX  = GW'(LOCK_CNT);
    localparam logic [MW-1:0]    MISS_MAX  = MW'(MISS_LIMIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]       state;
    logic [CBITS-1:0] cnt;
    logic [GW-1:0]    good_cnt;
    logic [MW-1:0]    miss_cnt;

    logic             in_track;
    logic             is_late;
    logic             is_early;
    logic             is_good;
    logic             miss_evt;
    logic [GW-1:0]    good_inc;
    logic [MW-1:0]    miss_inc;

    // The overdue check wins over a coincident tick, so a tick never sees cnt beyond PERIOD+TOL.
    assign in_track = (state == S_TRACK);
    assign is_late  = in_track && (cnt == LATE_AT);
    assign is_early = in_track && tick && !is_late && (cnt < EARLY_LIM);
    assign is_good  = in_track && tick && !is_late && !is_early;
    assign miss_evt = is_late || is_early;
    assign good_inc = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
    assign miss_inc = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            good_cnt <= '0;
            miss_cnt <= '0;
            locked   <= 1'b0;
            early    <= 1'b0;
            late     <= 1'b0;
            fault    <= 1'b0;
            interval <= '0;
        end else begin
            early <= is_early;
            late  <= is_late;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        state <= S_TRACK;
                        cnt   <= CBITS'(1);
                    end
                end
                S_TRACK: begin
                    cnt <= (tick || is_late) ? CBITS'(1) : cnt + 1'b1;
                    if (tick) begin
                        interval <= cnt;
                    end
                    if (miss_evt) begin
                        miss_cnt <= miss_inc;
                        good_cnt <= '0;
                        locked   <= 1'b0;
                        if (miss_inc == MISS_MAX) begin
                            state <= S_FAULT;
                            fault <= 1'b1;
                        end
                    end else if (is_good) begin
                        miss_cnt <= '0;
                        good_cnt <= good_inc;
                        if (good_inc == GOOD_MAX) begin
                            locked <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    // Ticks are ignored here; clr returns to IDLE so the next tick only re-arms.
                    if (clr) begin
                        state    <= S_IDLE;
                        fault    <= 1'b0;
                        cnt      <= '0;
                        good_cnt <= '0;
                        miss_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TICK_WDOG_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            miss_total   <= '0;
            max_interval <= '0;
        end else begin
            if (miss_evt && (miss_total != 16'hFFFF)) begin
                miss_total <= miss_total + 1'b1;
            end
            if (in_track && tick && (cnt > max_interval)) begin
                max_interval <= cnt;
            end
        end
    end
`endif

endmodule

// File: doc/tick_watchdog.md
Name: tick_watchdog

Overview:
Downstream consumer of the periodic one-cycle `sig` tick produced by the delay/tick generator stage. It measures the interval between consecutive ticks and classifies each tick as early, good or late. It reports lock once the tick train is stable. After repeated consecutive misses it latches a sticky fault, which only `clr` or `rst` removes.

Parameters:
PERIOD, 751, expected tick-to-tick interval in clk cycles (matches the generator's N=750)
TOL, 2, allowed deviation in cycles, applied on both sides of PERIOD
CBITS, 10, width of the interval counter; PERIOD+TOL+1 < 2**CBITS is required (elaboration check)
LOCK_CNT, 2, consecutive good ticks needed to assert locked
MISS_LIMIT, 3, consecutive misses (early or late) that trigger a fault

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
tick  in  1  one-cycle tick pulse from the generator
clr  in  1  clears a latched fault; ignored outside FAULT
locked  out  1  level: stable tick train
early  out  1  one-cycle pulse: tick arrived too soon
late  out  1  one-cycle pulse: tick overdue
fault  out  1  level, sticky: MISS_LIMIT consecutive misses
interval  out  CBITS  last measured tick interval

Behaviour:
- All outputs are registered. Each event's pulse appears in the cycle after the classification cycle (latency 1).
- Reset (`rst`=1):
  - State IDLE; cnt=0; good count=0; miss count=0.
  - locked=0, early=0, late=0, fault=0, interval=0.
  - `rst` has priority over every other input, including mid-interval and in FAULT.
- cnt = cycles elapsed since the last tick or restart. It is set to 1 in the cycle after a tick and increments by 1 every cycle. It never wraps, because the late restart bounds it.
- IDLE:
  - cnt is held at 0; no late detection.
  - First tick → TRACK, cnt restarts. The tick is not classified and interval is unchanged.
- TRACK, in a cycle with tick=1 and cnt ≤ PERIOD+TOL:
  - interval ← cnt.
  - cnt < PERIOD-TOL → early pulse; miss count +1 (saturating); good count ← 0; locked ← 0.
  - Otherwise good: miss count ← 0; good count +1, saturating at LOCK_CNT; locked ← 1 when good count reaches LOCK_CNT.
  - cnt restarts in both cases.
- TRACK, when cnt == PERIOD+TOL+1 (tick or not):
  - late pulse; miss count +1; good count ← 0; locked ← 0; cnt restarts.
  - interval is updated only if tick=1 in that cycle.
  - Late therefore repeats every PERIOD+TOL+1 cycles while the source is dead.
- TRACK → FAULT when the miss count reaches MISS_LIMIT.
  - fault ← 1 in the same registered update as the triggering early/late pulse.
- FAULT:
  - fault=1, locked=0; early and late stay at 0.
  - cnt and interval are held; tick is ignored.
  - clr=1 → IDLE, fault ← 0, miss and good counts ← 0. clr wins over a simultaneous tick, and that tick is ignored.
- Boundary cases:
  - tick at cnt == PERIOD-TOL or cnt == PERIOD+TOL is good.
  - clr outside FAULT has no effect.
  - Back-to-back ticks (cnt=1) are early.

Optional Feature:
Macro `TICK_WDOG_STATS_EN`.
- Defined:
  - Adds output `miss_total` [15:0]: a saturating count of all early and late events since `rst`. It is not cleared by `clr`.
  - Adds output `max_interval` [CBITS-1:0]: the largest interval captured since `rst`.
  - Both outputs reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- All tests use PERIOD=751 and TOL=2.
- After rst, ticks every 751 cycles → locked=1 one cycle after the 3rd tick (the 2nd classified good tick); interval=751; early, late and fault stay 0.
- Locked train, then one tick at 748 cycles → early pulse one cycle later; interval=748; locked=0. The next 751-cycle tick restores good count 1 and the one after relocks.
- Ticks at 749 and 753 cycles → both good; no early or late.
- Ticks stop after lock → late pulses 754, 1508 and 2262 cycles after the last tick; fault=1 with the 3rd late pulse. Further ticks are ignored; `clr` → IDLE, fault=0, and the next tick is not classified.
- `rst` asserted 400 cycles into TRACK with locked=1 → all outputs 0 next cycle and state IDLE. A tick 100 cycles later produces no early pulse.
- With `TICK_WDOG_STATS_EN` defined: 2 early ticks plus 1 late event → miss_total=3; a 753-cycle interval earlier → max_interval=753.
